// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
// Combinational content only; no latency.
// No flow control involved.
package serial_subtractor_pkg;

  // Two-state controller: waiting for a request, or shifting bits through the cell.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor (start/done handshake).
// Signal container only; no latency.
// start is ignored while busy is high; no queueing.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // Requester side drives operands and sees the result.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  // Subtractor side consumes operands and drives the result.
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor_fs.sv
// Gate-level full-subtractor cell: d = x - y - bi, bo = borrow out.
// Purely combinational, zero cycles.
// No flow control.
module full_subtractor (
  input  logic x_i,
  input  logic y_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  logic x_xor_y;

  assign x_xor_y = x_i ^ y_i;
  assign d_o     = x_xor_y ^ bi_i;
  // Borrow when x=0,y=1, or when x==y and a borrow comes in.
  assign bo_o    = (~x_i & y_i) | (~x_xor_y & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin mod 2^WIDTH, bout = final borrow.
// Latency: WIDTH shift cycles after the accepting edge, then a one-cycle done pulse.
// start is only sampled while idle; requests during a shift are dropped.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  sub_if
);

  import serial_subtractor_pkg::*;

  localparam int                CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  // Next result bit and next borrow come straight from the single cell.
  logic             bit_d;
  logic             br_d;

  full_subtractor u_fs (
    .x_i  (a_q[0]),
    .y_i  (b_q[0]),
    .bi_i (br_q),
    .d_o  (bit_d),
    .bo_o (br_d)
  );

  // Controller, operand shifters, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      count_q <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // diff/bout keep the previous result until a new op is accepted.
          if (sub_if.start) begin
            a_q     <= sub_if.a;
            b_q     <= sub_if.b;
            br_q    <= sub_if.bin;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // LSB-first: each new bit enters at the top and walks down.
          diff_q  <= {bit_d, diff_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          br_q    <= br_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) begin
            bout_q  <= br_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sub_if.busy = busy_q;
  assign sub_if.done = done_q;
  assign sub_if.diff = diff_q;
  assign sub_if.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sub_if (if8.slave)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sub_if (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: pops the scoreboard on every done pulse.
  task automatic mon8();
    logic       done_prev;
    logic [8:0] e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_prev) chk("done8_single_pulse", 32'(if8.done), 32'd0);
      if (if8.done) begin
        chk("busy8_low_in_done", 32'(if8.busy), 32'd0);
        if (q8.size() == 0) begin
          chk("done8_unexpected", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          chk("diff8", 32'(if8.diff), 32'(e[7:0]));
          chk("bout8", 32'(if8.bout), 32'(e[8]));
        end
      end
      done_prev = if8.done;
    end
  endtask

  // Monitor for the 4-bit instance.
  task automatic mon4();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (if4.done) begin
        if (q4.size() == 0) begin
          chk("done4_unexpected", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          chk("diff4", 32'(if4.diff), 32'(e[3:0]));
          chk("bout4", 32'(if4.bout), 32'(e[4]));
        end
      end
    end
  endtask

  // Called just after a posedge; returns just after the edge that raised done.
  task automatic wait_done8();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done8_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done4();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if4.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done4_timeout", 32'd1, 32'd0);
  endtask

  // Issue one 8-bit op (expected = {bout, diff}) and wait for its done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [8:0] exp);
    q8.push_back(exp);
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    if8.bin   = bin;
    @(posedge clk); #1;
    if8.start = 1'b0;
    wait_done8();
  endtask

  initial begin
    int         done_cnt;
    logic [3:0] av;
    logic [3:0] bv;
    logic       cv;
    logic [4:0] r;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;

    fork
      begin #400000; $display("FAIL watchdog expired"); $fatal(1); end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", 32'(if8.busy), 32'd0);
    chk("rst_done8", 32'(if8.done), 32'd0);
    chk("rst_diff8", 32'(if8.diff), 32'd0);
    chk("rst_bout8", 32'(if8.bout), 32'd0);
    chk("rst_busy4", 32'(if4.busy), 32'd0);
    chk("rst_diff4", 32'(if4.diff), 32'd0);
    rst_n = 1'b1;

    fork
      mon8();
      mon4();
    join_none

    @(posedge clk); #1;

    // Basic vectors, issued back to back (each start lands in the previous done cycle).
    op8(8'd5,   8'd3,   1'b0, {1'b0, 8'h02});
    op8(8'd3,   8'd5,   1'b0, {1'b1, 8'hFE});
    op8(8'd0,   8'd0,   1'b1, {1'b1, 8'hFF});
    op8(8'h80,  8'h01,  1'b0, {1'b0, 8'h7F});

    // Start during a shift is ignored; start in the done cycle is accepted.
    q8.push_back({1'b0, 8'h07});
    if8.start = 1'b1; if8.a = 8'h0A; if8.b = 8'h03; if8.bin = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy8_mid_shift", 32'(if8.busy), 32'd1);
    if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'h00; if8.bin = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    wait_done8();
    op8(8'd9, 8'd4, 1'b0, {1'b0, 8'h05});

    // Reset in the middle of a shift aborts the op without a done pulse.
    repeat (2) @(posedge clk);
    #1;
    if8.start = 1'b1; if8.a = 8'h40; if8.b = 8'h11; if8.bin = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy8", 32'(if8.busy), 32'd0);
    chk("abort_done8", 32'(if8.done), 32'd0);
    chk("abort_diff8", 32'(if8.diff), 32'd0);
    chk("abort_bout8", 32'(if8.bout), 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if8.done) done_cnt++;
    end
    chk("abort_no_done8", 32'(done_cnt), 32'd0);
    op8(8'h40, 8'h11, 1'b0, {1'b0, 8'h2F});
    @(posedge clk); #1;
    chk("hold_diff8", 32'(if8.diff), 32'h2F);

    // Exhaustive 4-bit sweep against a wider-precision reference.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          av = 4'(ia);
          bv = 4'(ib);
          cv = 1'(ic);
          r  = {1'b0, av} - {1'b0, bv} - {4'b0, cv};
          q4.push_back(r);
          if4.start = 1'b1; if4.a = av; if4.b = bv; if4.bin = cv;
          @(posedge clk); #1;
          if4.start = 1'b0;
          wait_done4();
        end
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
